bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared 32-bit tri-state data bus.
- Its one-hot grant vector drives the cs inputs of the per-master 32-bit tri-state bus drivers, so at most one master drives the bus in any cycle.
- Enforces a maximum bus tenure (timeout) and, optionally, a one-cycle dead turnaround between owners to prevent driver overlap.

Parameters:
- N_REQ, 4, number of bus masters; 2..8 supported.
- MAX_HOLD, 16, maximum consecutive cycles one master may hold the grant; 1..255.
- OWN_W, $clog2(N_REQ), width of the owner index.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-master bus request; level, held for the whole transfer.
- gnt  output  N_REQ  one-hot grant, registered; bit i wires to master i's tri-state driver cs.
- owner  output  OWN_W  index of current grant holder; valid only while busy=1.
- busy  output  1  1 when any gnt bit is set.
- timeout  output  1  one-cycle pulse on a forced release at MAX_HOLD.

Behaviour:
- Reset (asynchronous, immediate, also mid-grant):
  - gnt=0, owner=0, busy=0, timeout=0.
  - state=IDLE, hold_cnt=0, rr pointer ptr=0 (master 0 highest priority).
- Invariant: gnt is zero or one-hot in every cycle, including reset release. All outputs are registered.
- Arbitration function: first asserted req[i] scanning i = ptr, ptr+1, ..., wrapping mod N_REQ.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req != 0, the winner's gnt bit is set at the next edge; owner=winner, busy=1, hold_cnt=1, go to GRANT.
  - Latency: req sampled high at edge k gives gnt high after edge k.
  - If req == 0, stay in IDLE with gnt=0.
- GRANT (each edge):
  - Normal release: req[owner]=0.
  - Forced release: req[owner]=1 and hold_cnt==MAX_HOLD. Assert timeout for exactly one cycle, coincident with the release edge.
  - If req[owner] drops on the same cycle hold_cnt reaches MAX_HOLD, it is a normal release; no timeout.
  - On either release: ptr = (owner+1) mod N_REQ, so the releasing master has lowest priority next.
  - Otherwise hold gnt and increment hold_cnt; it saturates at MAX_HOLD and never wraps.
- After release, with turnaround: gnt=0, busy=0 for exactly one cycle (TURN). TURN arbitrates as IDLE using the updated ptr.
- After release, without turnaround: the release edge arbitrates directly with the updated ptr. gnt switches old-to-new one-hot at a single edge, or goes to 0 if no other request is pending.
- A force-released master still requesting is re-granted only if no other master requests. With turnaround it is re-granted after the TURN cycle.
- Requests from non-owners never affect the current grant; there is no preemption.
- req bits rising and falling while not granted are ignored, with no latching.
- owner holds its last value while busy=0.

Optional Feature:
- Macro: BUS_TURNAROUND_EN.
- Defined: a TURN state is inserted after every release, giving one cycle of all-zero gnt between owners, so no two bus drivers are enabled at adjacent edges.
- Undefined: the TURN state is not compiled. Handoff is back-to-back as described under Behaviour, saving one cycle per ownership change.

Test Plan:
- Reset mid-grant: gnt=4'b0010, assert rst asynchronously between edges → gnt=0, busy=0 immediately; after deassert with req=4'b1000 → gnt=4'b1000 one edge later.
- Round-robin: req=4'b1111 held, each master drops req after 3 granted cycles then re-raises → grant order 0,1,2,3,0. With BUS_TURNAROUND_EN, exactly one gnt=0 cycle between owners; without it, none.
- Timeout: MAX_HOLD=16, req=4'b0001 held, req[2] raised at cycle 5 → gnt[0] high exactly 16 cycles, timeout pulses once, next owner=2.
- Simultaneous release/timeout: req[owner] drops on the 16th granted cycle → timeout stays 0, ptr advances normally.
- Lone requester re-grant: req=4'b0100 held forever → repeated 16-cycle grants to master 2, timeout pulse each, one-cycle gap only when BUS_TURNAROUND_EN is defined.
- One-hot check: random req over 10k cycles → gnt always 0 or one-hot; busy==|gnt; owner matches the gnt index whenever busy=1.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter with maximum-tenure timeout driving one-hot tri-state bus chip selects.
// Define BUS_TURNAROUND_EN to insert a one-cycle all-zero TURN state between bus owners.
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    parameter int OWN_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [OWN_W-1:0] owner,
    output logic             busy,
    output logic             timeout
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [OWN_W-1:0]  LAST     = OWN_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT
`ifdef BUS_TURNAROUND_EN
        , TURN
`endif
    } state_t;

    // Returns {found, index} of the first set request scanning from start, wrapping.
    function automatic logic [OWN_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [OWN_W-1:0] start);
        logic             found;
        logic [OWN_W-1:0] idx;
        int unsigned      pos;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pos = 32'(start) + i;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (!found && r[pos[OWN_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[OWN_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [OWN_W-1:0]  ptr, ptr_nxt, ptr_rel;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [OWN_W-1:0]  owner_nxt;
    logic              busy_nxt;
    logic              timeout_nxt;
    logic              grant_new;
    logic [OWN_W-1:0]  grant_idx;
    logic              forced;
    logic [OWN_W:0]    pick_idle;
`ifndef BUS_TURNAROUND_EN
    logic [OWN_W:0]    pick_rel;
`endif

    // The releasing master becomes lowest priority.
    assign ptr_rel   = (owner == LAST) ? '0 : owner + 1'b1;
    assign pick_idle = rr_pick(req, ptr);
`ifndef BUS_TURNAROUND_EN
    assign pick_rel  = rr_pick(req, ptr_rel);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            ptr      <= '0;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            ptr      <= ptr_nxt;
            gnt      <= gnt_nxt;
            owner    <= owner_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        ptr_nxt   = ptr;
        grant_new = 1'b0;
        grant_idx = pick_idle[OWN_W-1:0];
        forced    = 1'b0;
        case (state)
            GRANT: begin
                if (!req[owner] || hold_cnt == HOLD_MAX) begin
                    // A drop on the final allowed cycle counts as a normal release.
                    forced   = req[owner];
                    ptr_nxt  = ptr_rel;
                    hold_nxt = '0;
`ifdef BUS_TURNAROUND_EN
                    state_nxt = TURN;
`else
                    grant_idx = pick_rel[OWN_W-1:0];
                    if (pick_rel[OWN_W]) begin
                        grant_new = 1'b1;
                        hold_nxt  = HOLD_ONE;
                        state_nxt = GRANT;
                    end else begin
                        state_nxt = IDLE;
                    end
`endif
                end else begin
                    hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
                end
            end
            default: begin
                if (pick_idle[OWN_W]) begin
                    grant_new = 1'b1;
                    hold_nxt  = HOLD_ONE;
                    state_nxt = GRANT;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        gnt_nxt     = gnt;
        owner_nxt   = owner;
        busy_nxt    = busy;
        timeout_nxt = forced;
        if (grant_new) begin
            gnt_nxt   = N_REQ'(1) << grant_idx;
            owner_nxt = grant_idx;
            busy_nxt  = 1'b1;
        end else if (state_nxt != GRANT) begin
            gnt_nxt  = '0;
            busy_nxt = 1'b0;
        end
    end

    assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    assert property (@(posedge clk) disable iff (rst) busy == (|gnt));

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a cycle model pushes expected outputs per edge, checked after the edge.
module tb_bus_arbiter;
    localparam int N    = 4;
    localparam int MAXH = 16;
    localparam int OW   = 2;
`ifdef BUS_TURNAROUND_EN
    localparam bit TA = 1'b1;
`else
    localparam bit TA = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt;
    logic [OW-1:0] owner;
    logic          busy;
    logic          timeout;

    bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH), .OWN_W(OW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [OW-1:0] owner;
        logic          busy;
        logic          timeout;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [N-1:0] m_gnt;
    int           m_owner, m_hold, m_ptr;
    bit           m_busy, m_to;

    int           exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] r;
    int           n_grants, gap, g0, to_cnt, next_owner;
    bit           prev_busy;
    int           prev_owner;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gnt_index(input logic [N-1:0] g);
        int idx = -1;
        for (int i = 0; i < N; i++) if (g[i]) idx = i;
        return idx;
    endfunction

    task automatic model_reset();
        m_gnt = '0; m_owner = 0; m_hold = 0; m_ptr = 0; m_busy = 1'b0; m_to = 1'b0;
    endtask

    task automatic model_arb(input logic [N-1:0] rq);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (rq[i]) begin
                m_busy = 1'b1; m_owner = i; m_hold = 1;
                m_gnt = '0; m_gnt[i] = 1'b1;
                return;
            end
        end
    endtask

    task automatic model_step(input logic [N-1:0] rq);
        m_to = 1'b0;
        if (m_busy) begin
            if (!rq[m_owner] || m_hold == MAXH) begin
                m_to   = rq[m_owner];
                m_ptr  = (m_owner + 1) % N;
                m_busy = 1'b0;
                m_gnt  = '0;
                if (!TA) model_arb(rq);
            end else begin
                m_hold++;
            end
        end else begin
            model_arb(rq);
        end
    endtask

    // Called just after an active edge; drives req, predicts the next edge, then checks it.
    task automatic cycle(input logic [N-1:0] rq);
        exp_t e;
        req = rq;
        model_step(rq);
        sb_q.push_back('{gnt: m_gnt, owner: OW'(m_owner), busy: m_busy, timeout: m_to});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("gnt", gnt, e.gnt);
        check_eq("owner", owner, e.owner);
        check_eq("busy", busy, e.busy);
        check_eq("timeout", timeout, e.timeout);
        check_eq("onehot0", $onehot0(gnt), 1);
        check_eq("busy_vs_gnt", busy, |gnt);
        if (busy) check_eq("owner_vs_gnt", owner, gnt_index(gnt));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_timeout", timeout, 0);
        rst = 1'b0;
        model_reset();
        sb_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Asynchronous reset in the middle of a grant
        apply_reset();
        cycle(4'b0010);
        check_eq("mid_gnt", gnt, 4'b0010);
        cycle(4'b0010);
        #2 rst = 1'b1;
        #1;
        check_eq("async_gnt", gnt, 0);
        check_eq("async_busy", busy, 0);
        check_eq("async_owner", owner, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        sb_q.delete();
        cycle(4'b1000);
        check_eq("post_rst_gnt", gnt, 4'b1000);

        // Round robin: each owner drops its request on its third granted cycle
        apply_reset();
        n_grants = 0; gap = 0; prev_busy = 1'b0; prev_owner = 0;
        for (int c = 0; c < 80 && n_grants < 5; c++) begin
            r = 4'b1111;
            if (m_busy && m_hold == 3) r[m_owner] = 1'b0;
            cycle(r);
            if (busy && (!prev_busy || owner != prev_owner)) begin
                check_eq("rr_order", owner, exp_order[n_grants]);
                if (n_grants > 0) check_eq("rr_gap", gap, TA ? 1 : 0);
                n_grants++;
                gap = 0;
            end else if (!busy && n_grants > 0) begin
                gap++;
            end
            prev_busy  = busy;
            prev_owner = owner;
        end
        check_eq("rr_count", n_grants, 5);

        // Forced release at MAX_HOLD with a competing request
        apply_reset();
        g0 = 0; to_cnt = 0; next_owner = -1;
        for (int c = 0; c < 30; c++) begin
            cycle(c >= 5 ? 4'b0101 : 4'b0001);
            if (gnt[0]) g0++;
            if (timeout) to_cnt++;
            if (busy && owner != 0 && next_owner < 0) next_owner = owner;
        end
        check_eq("to_hold", g0, MAXH);
        check_eq("to_pulses", to_cnt, 1);
        check_eq("to_next", next_owner, 2);

        // Request drops on the final allowed cycle: normal release
        apply_reset();
        g0 = 0; to_cnt = 0; next_owner = -1;
        for (int c = 0; c < 25; c++) begin
            r = 4'b1001;
            if (m_busy && m_owner == 0 && m_hold == MAXH) r = 4'b1000;
            cycle(r);
            if (gnt[0]) g0++;
            if (timeout) to_cnt++;
            if (busy && owner != 0 && next_owner < 0) next_owner = owner;
        end
        check_eq("sim_hold", g0, MAXH);
        check_eq("sim_pulses", to_cnt, 0);
        check_eq("sim_next", next_owner, 3);

        // Lone requester is repeatedly re-granted after each timeout
        apply_reset();
        to_cnt = 0; gap = 0;
        for (int c = 0; c < 60; c++) begin
            cycle(4'b0100);
            if (timeout) to_cnt++;
            if (!busy) gap++;
        end
        check_eq("lone_pulses", to_cnt, 3);
        check_eq("lone_gaps", gap, TA ? 3 : 0);

        // Random request traffic with occasional changes so tenures can reach the limit
        apply_reset();
        r = '0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) r = N'($urandom);
            cycle(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
